// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control FSM: state encodings,
// ALU op codes, opcode/funct values, datapath select codes and dispatch.
package mc_ctrl_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_RTYPE_EX = 4'd6;
  localparam logic [3:0] S_RTYPE_WB = 4'd7;
  localparam logic [3:0] S_ORI_EX   = 4'd8;
  localparam logic [3:0] S_LUI_EX   = 4'd9;
  localparam logic [3:0] S_IMM_WB   = 4'd10;
  localparam logic [3:0] S_BRANCH   = 4'd11;
  localparam logic [3:0] S_JUMP     = 4'd12;
  localparam logic [3:0] S_JAL      = 4'd13;
  localparam logic [3:0] S_JR       = 4'd14;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] SA_PC   = 2'd0;
  localparam logic [1:0] SA_REGA = 2'd1;
  localparam logic [1:0] SA_ZERO = 2'd2;

  localparam logic [1:0] SB_REGB    = 2'd0;
  localparam logic [1:0] SB_FOUR    = 2'd1;
  localparam logic [1:0] SB_IMM     = 2'd2;
  localparam logic [1:0] SB_IMM_SL2 = 2'd3;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] PCS_REGA   = 2'd3;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  // Returns the first execute state for an instruction; S_FETCH means unsupported.
  function automatic logic [3:0] dispatch(input logic [5:0] opcode, input logic [5:0] funct);
    logic [3:0] target;
    target = S_FETCH;
    case (opcode)
      OP_LW, OP_SW: target = S_MEMADR;
      OP_ORI:       target = S_ORI_EX;
      OP_LUI:       target = S_LUI_EX;
      OP_BEQ:       target = S_BRANCH;
      OP_J:         target = S_JUMP;
      OP_JAL:       target = S_JAL;
      OP_RTYPE: begin
        if (funct == FN_ADDU || funct == FN_SUBU) target = S_RTYPE_EX;
        else if (funct == FN_JR)                  target = S_JR;
      end
      default:      target = S_FETCH;
    endcase
    return target;
  endfunction

endpackage

// File: rtl/mc_ctrl_out.sv
// Combinational control decoder: state (plus funct/opcode in RTYPE_EX and
// DECODE) to the datapath control vector. Unused encodings drive all zeros.
module mc_ctrl_out
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  output logic [2:0]         ALUop,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ExtOp,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic [1:0]         PCSource,
  output logic               RegWrite,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic               instr_done,
  output logic               illegal
);

  always_comb begin
    ALUop       = ALU_ADD;
    ALUSrcA     = SA_PC;
    ALUSrcB     = SB_REGB;
    ExtOp       = EXT_ZERO;
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = PCS_ALU;
    RegWrite    = 1'b0;
    RegDst      = RD_RT;
    MemtoReg    = M2R_ALUOUT;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    case (state)
      STATE_W'(S_FETCH): begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = SB_FOUR;
      end
      STATE_W'(S_DECODE): begin
        // Branch target is computed here speculatively into ALUOut.
        ALUSrcB = SB_IMM_SL2;
        ExtOp   = EXT_SIGN;
        if (dispatch(opcode, funct) == S_FETCH) begin
          illegal    = 1'b1;
          instr_done = 1'b1;
        end
      end
      STATE_W'(S_MEMADR): begin
        ALUSrcA = SA_REGA;
        ALUSrcB = SB_IMM;
        ExtOp   = EXT_SIGN;
      end
      STATE_W'(S_MEMRD): IorD = 1'b1;
      STATE_W'(S_MEMWB): begin
        RegWrite   = 1'b1;
        MemtoReg   = M2R_MDR;
        instr_done = 1'b1;
      end
      STATE_W'(S_MEMWR): begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = 1'b1;
      end
      STATE_W'(S_RTYPE_EX): begin
        ALUSrcA = SA_REGA;
        ALUop   = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
      end
      STATE_W'(S_RTYPE_WB): begin
        RegWrite   = 1'b1;
        RegDst     = RD_RD;
        instr_done = 1'b1;
      end
      STATE_W'(S_ORI_EX): begin
        ALUSrcA = SA_REGA;
        ALUSrcB = SB_IMM;
        ALUop   = ALU_OR;
      end
      STATE_W'(S_LUI_EX): begin
        ALUSrcA = SA_ZERO;
        ALUSrcB = SB_IMM;
        ExtOp   = EXT_LUI;
      end
      STATE_W'(S_IMM_WB): begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      STATE_W'(S_BRANCH): begin
        ALUSrcA     = SA_REGA;
        ALUop       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCS_ALUOUT;
        instr_done  = 1'b1;
      end
      STATE_W'(S_JUMP): begin
        PCWrite    = 1'b1;
        PCSource   = PCS_JUMP;
        instr_done = 1'b1;
      end
      STATE_W'(S_JAL): begin
        PCWrite    = 1'b1;
        PCSource   = PCS_JUMP;
        RegWrite   = 1'b1;
        RegDst     = RD_RA;
        MemtoReg   = M2R_PC;
        instr_done = 1'b1;
      end
      STATE_W'(S_JR): begin
        PCWrite    = 1'b1;
        PCSource   = PCS_REGA;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: state register and next-state logic.
// Optional MC_CTRL_PERF_EN adds cycle_cnt/instr_cnt performance counters.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic [2:0]         ALUop,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ExtOp,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic [1:0]         PCSource,
  output logic               RegWrite,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic               instr_done,
  output logic               illegal,
`ifdef MC_CTRL_PERF_EN
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instr_cnt,
`endif
  output logic [STATE_W-1:0] state
);

  logic [STATE_W-1:0] state_reg;
  logic [STATE_W-1:0] state_next;
  logic mem_write_raw, ir_write_raw, pc_write_raw, pc_write_cond_raw;
  logic reg_write_raw, done_raw, illegal_raw;
  logic zero_unused;

  // Branch qualification happens in the datapath; the flag is only observed.
  assign zero_unused = zero;

  always_comb begin
    state_next = STATE_W'(S_FETCH);
    case (state_reg)
      STATE_W'(S_FETCH):    state_next = STATE_W'(S_DECODE);
      STATE_W'(S_DECODE):   state_next = STATE_W'(dispatch(opcode, funct));
      STATE_W'(S_MEMADR):   state_next = (opcode == OP_LW) ? STATE_W'(S_MEMRD) : STATE_W'(S_MEMWR);
      STATE_W'(S_MEMRD):    state_next = STATE_W'(S_MEMWB);
      STATE_W'(S_RTYPE_EX): state_next = STATE_W'(S_RTYPE_WB);
      STATE_W'(S_ORI_EX),
      STATE_W'(S_LUI_EX):   state_next = STATE_W'(S_IMM_WB);
      default:              state_next = STATE_W'(S_FETCH);
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= STATE_W'(S_FETCH);
    else        state_reg <= state_next;
  end

  mc_ctrl_out #(.STATE_W(STATE_W)) u_out (
    .state       (state_reg),
    .opcode      (opcode),
    .funct       (funct),
    .ALUop       (ALUop),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ExtOp       (ExtOp),
    .IorD        (IorD),
    .MemWrite    (mem_write_raw),
    .IRWrite     (ir_write_raw),
    .PCWrite     (pc_write_raw),
    .PCWriteCond (pc_write_cond_raw),
    .PCSource    (PCSource),
    .RegWrite    (reg_write_raw),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .instr_done  (done_raw),
    .illegal     (illegal_raw)
  );

  // FETCH is the reset state but must not write anything while held in reset.
  assign MemWrite    = mem_write_raw & reset;
  assign IRWrite     = ir_write_raw & reset;
  assign PCWrite     = pc_write_raw & reset;
  assign PCWriteCond = pc_write_cond_raw & reset;
  assign RegWrite    = reg_write_raw & reset;
  assign instr_done  = done_raw & reset;
  assign illegal     = illegal_raw & reset;
  assign state       = state_reg;

`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt_reg;
  logic [31:0] instr_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_reg <= 32'd0;
      instr_cnt_reg <= 32'd0;
    end else begin
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      if (done_raw) instr_cnt_reg <= instr_cnt_reg + 32'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_reg;
  assign instr_cnt = instr_cnt_reg;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed testbench for mc_ctrl: walks each instruction class through its
// states and checks controls against hand-computed values.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] ALUop;
  logic [1:0] ALUSrcA, ALUSrcB, ExtOp, PCSource, RegDst, MemtoReg;
  logic       IorD, MemWrite, IRWrite, PCWrite, PCWriteCond, RegWrite;
  logic       instr_done, illegal;
  logic [3:0] state;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  int checks = 0;
  int errors = 0;

  mc_ctrl #(.STATE_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .ALUop       (ALUop),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ExtOp       (ExtOp),
    .IorD        (IorD),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .PCSource    (PCSource),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .instr_done  (instr_done),
    .illegal     (illegal),
`ifdef MC_CTRL_PERF_EN
    .cycle_cnt   (cycle_cnt),
    .instr_cnt   (instr_cnt),
`endif
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; opcode = OP_LW; funct = 6'h00; zero = 1'b0;
    step(3);
    check("rst_state", 32'(state), 32'(S_FETCH));
    check("rst_irwrite", 32'(IRWrite), 32'd0);
    check("rst_pcwrite", 32'(PCWrite), 32'd0);
    check("rst_memwrite", 32'(MemWrite), 32'd0);
    check("rst_regwrite", 32'(RegWrite), 32'd0);
    check("rst_pcwcond", 32'(PCWriteCond), 32'd0);
    check("rst_done", 32'(instr_done), 32'd0);
    reset = 1'b1; #1;
    check("fetch_irwrite", 32'(IRWrite), 32'd1);
    check("fetch_pcwrite", 32'(PCWrite), 32'd1);
    check("fetch_aluop", 32'(ALUop), 32'd0);
    check("fetch_srcb", 32'(ALUSrcB), 32'd1);
    check("fetch_iord", 32'(IorD), 32'd0);

    // lw: 5 cycles
    step(1);
    check("lw_decode", 32'(state), 32'(S_DECODE));
    check("dec_srcb", 32'(ALUSrcB), 32'd3);
    check("dec_extop", 32'(ExtOp), 32'd1);
    check("dec_irwrite", 32'(IRWrite), 32'd0);
    step(1);
    check("lw_memadr", 32'(state), 32'(S_MEMADR));
    check("memadr_srca", 32'(ALUSrcA), 32'd1);
    check("memadr_srcb", 32'(ALUSrcB), 32'd2);
    step(1);
    check("lw_memrd", 32'(state), 32'(S_MEMRD));
    check("memrd_iord", 32'(IorD), 32'd1);
    check("memrd_regwrite", 32'(RegWrite), 32'd0);
    step(1);
    check("lw_memwb", 32'(state), 32'(S_MEMWB));
    check("memwb_regwrite", 32'(RegWrite), 32'd1);
    check("memwb_memtoreg", 32'(MemtoReg), 32'd1);
    check("memwb_done", 32'(instr_done), 32'd1);
    step(1);
    check("lw_end", 32'(state), 32'(S_FETCH));

    // sw: 4 cycles
    opcode = OP_SW;
    step(3);
    check("sw_memwr", 32'(state), 32'(S_MEMWR));
    check("sw_memwrite", 32'(MemWrite), 32'd1);
    check("sw_iord", 32'(IorD), 32'd1);
    check("sw_done", 32'(instr_done), 32'd1);
    step(1);
    check("sw_end", 32'(state), 32'(S_FETCH));

    // subu then addu
    opcode = OP_RTYPE; funct = FN_SUBU;
    step(2);
    check("subu_ex", 32'(state), 32'(S_RTYPE_EX));
    check("subu_aluop", 32'(ALUop), 32'd1);
    check("subu_srca", 32'(ALUSrcA), 32'd1);
    check("subu_srcb", 32'(ALUSrcB), 32'd0);
    step(1);
    check("rtype_wb_regwrite", 32'(RegWrite), 32'd1);
    check("rtype_wb_regdst", 32'(RegDst), 32'd1);
    check("rtype_wb_done", 32'(instr_done), 32'd1);
    step(1);
    check("subu_end", 32'(state), 32'(S_FETCH));
    funct = FN_ADDU;
    step(2);
    check("addu_aluop", 32'(ALUop), 32'd0);
    step(2);
    check("addu_end", 32'(state), 32'(S_FETCH));

    // beq with zero=1 and zero=0
    for (int zi = 1; zi >= 0; zi--) begin
      opcode = OP_BEQ; zero = zi[0];
      step(2);
      check($sformatf("beq%0d_state", zi), 32'(state), 32'(S_BRANCH));
      check($sformatf("beq%0d_pcwcond", zi), 32'(PCWriteCond), 32'd1);
      check($sformatf("beq%0d_aluop", zi), 32'(ALUop), 32'd1);
      check($sformatf("beq%0d_pcsrc", zi), 32'(PCSource), 32'd1);
      step(1);
      check($sformatf("beq%0d_end", zi), 32'(state), 32'(S_FETCH));
    end

    // ori and lui
    opcode = OP_ORI;
    step(2);
    check("ori_aluop", 32'(ALUop), 32'd2);
    check("ori_extop", 32'(ExtOp), 32'd0);
    check("ori_srcb", 32'(ALUSrcB), 32'd2);
    step(1);
    check("imm_wb_state", 32'(state), 32'(S_IMM_WB));
    check("imm_wb_regwrite", 32'(RegWrite), 32'd1);
    check("imm_wb_regdst", 32'(RegDst), 32'd0);
    step(1);
    opcode = OP_LUI;
    step(2);
    check("lui_srca", 32'(ALUSrcA), 32'd2);
    check("lui_extop", 32'(ExtOp), 32'd2);
    step(2);
    check("lui_end", 32'(state), 32'(S_FETCH));

    // jal, jr, j
    opcode = OP_JAL;
    step(2);
    check("jal_pcwrite", 32'(PCWrite), 32'd1);
    check("jal_pcsrc", 32'(PCSource), 32'd2);
    check("jal_regdst", 32'(RegDst), 32'd2);
    check("jal_memtoreg", 32'(MemtoReg), 32'd2);
    check("jal_regwrite", 32'(RegWrite), 32'd1);
    step(1);
    opcode = OP_RTYPE; funct = FN_JR;
    step(2);
    check("jr_state", 32'(state), 32'(S_JR));
    check("jr_pcsrc", 32'(PCSource), 32'd3);
    step(1);
    opcode = OP_J;
    step(2);
    check("j_pcsrc", 32'(PCSource), 32'd2);
    check("j_done", 32'(instr_done), 32'd1);
    step(1);
    check("j_end", 32'(state), 32'(S_FETCH));

    // illegal opcode: 2 cycles
    opcode = 6'h3F;
    step(1);
    check("ill_illegal", 32'(illegal), 32'd1);
    check("ill_done", 32'(instr_done), 32'd1);
    check("ill_regwrite", 32'(RegWrite), 32'd0);
    check("ill_memwrite", 32'(MemWrite), 32'd0);
    step(1);
    check("ill_end", 32'(state), 32'(S_FETCH));
    check("ill_cleared", 32'(illegal), 32'd0);

    // reset in MEMRD of a lw
    opcode = OP_LW;
    step(3);
    check("abort_memrd", 32'(state), 32'(S_MEMRD));
    reset = 1'b0; #1;
    check("abort_state", 32'(state), 32'(S_FETCH));
    check("abort_regwrite", 32'(RegWrite), 32'd0);
    check("abort_irwrite", 32'(IRWrite), 32'd0);
    step(1);
    check("abort_hold_regwrite", 32'(RegWrite), 32'd0);
    opcode = OP_ORI;
    reset = 1'b1; #1;
`ifdef MC_CTRL_PERF_EN
    check("perf_instr0", instr_cnt, 32'd0);
    check("perf_cycle0", cycle_cnt, 32'd0);
`endif
    step(1);
    check("post_rst_decode", 32'(state), 32'(S_DECODE));
`ifdef MC_CTRL_PERF_EN
    check("perf_cycle1", cycle_cnt, 32'd1);
`endif
    step(3);
    check("post_rst_end", 32'(state), 32'(S_FETCH));
`ifdef MC_CTRL_PERF_EN
    check("perf_instr1", instr_cnt, 32'd1);
    check("perf_cycle4", cycle_cnt, 32'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
